// File: rtl/regfile_mp_if.sv
// regfile_mp_if
// Bundles the register file's decode/writeback-facing signals.
//   wen    - write enable from writeback
//   waddr  - write index
//   wdata  - write data
//   raddr  - flattened read indices, port i at [i*ADDR_WIDTH +: ADDR_WIDTH]
//   rdata  - flattened read data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   ready  - array initialised and accepting writes
// master: the pipeline side driving indices/writes.
// slave : the register file itself.
interface regfile_mp_if #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2
);
    logic                           wen;
    logic [ADDR_WIDTH-1:0]          waddr;
    logic [DATA_WIDTH-1:0]          wdata;
    logic [NR_READ*ADDR_WIDTH-1:0]  raddr;
    logic [NR_READ*DATA_WIDTH-1:0]  rdata;
    logic                           ready;

    modport master (
        output wen, waddr, wdata, raddr,
        input  rdata, ready
    );

    modport slave (
        input  wen, waddr, wdata, raddr,
        output rdata, ready
    );
endinterface

// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-read-port integer register file with an optional hardwired-zero
// entry 0 and a post-reset clear sweep.
//   clk  - single clock, all state changes on posedge
//   rst  - synchronous active-high reset; restarts the clear sweep
//   bus  - regfile_mp_if.slave (wen/waddr/wdata write port, raddr/rdata
//          combinational read ports, ready flag)
// Optional feature: define REGFILE_MP_BYPASS_EN to forward the write data
// to any read port addressing the entry being written in the same cycle.
module regfile_mp #(
    parameter int ADDR_WIDTH = 5,
    parameter int DATA_WIDTH = 32,
    parameter int NR_READ    = 2,
    parameter int ZERO_REG   = 1
) (
    input  logic         clk,
    input  logic         rst,
    regfile_mp_if.slave  bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] LAST_IDX = (ADDR_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                 state;
    logic [ADDR_WIDTH:0]    counter;
    logic                   ready_q;
    logic [DATA_WIDTH-1:0]  regs [DEPTH];
    logic                   write_blocked;
    logic [NR_READ*DATA_WIDTH-1:0] rdata_flat;

    // A write to entry 0 is swallowed when the zero register is enabled.
    assign write_blocked = (ZERO_REG != 0) && (bus.waddr == '0);

    // Sweep controller: after reset, walk the counter across every entry
    // once, then raise ready for good until the next reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= INIT;
            counter <= '0;
            ready_q <= 1'b0;
        end else if (state == INIT) begin
            counter <= counter + 1'b1;
            if (counter == LAST_IDX) begin
                state   <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // Array update: the sweep owns the write port during INIT, so pipeline
    // writes there are dropped; reset also drops any write in flight.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == INIT) begin
                regs[counter[ADDR_WIDTH-1:0]] <= '0;
            end else if (bus.wen && !write_blocked) begin
                regs[bus.waddr] <= bus.wdata;
            end
        end
    end

    // Read ports: purely combinational. INIT forces zero so stale contents
    // never leak out before the sweep finishes.
    always_comb begin
        rdata_flat = '0;
        for (int i = 0; i < NR_READ; i++) begin
            logic [ADDR_WIDTH-1:0] ra;
            logic [DATA_WIDTH-1:0] val;
            ra  = bus.raddr[i*ADDR_WIDTH +: ADDR_WIDTH];
            val = regs[ra];
`ifdef REGFILE_MP_BYPASS_EN
            if (bus.wen && !write_blocked && (bus.waddr == ra)) begin
                val = bus.wdata;
            end
`else
`endif
            if (state == INIT) begin
                val = '0;
            end else if ((ZERO_REG != 0) && (ra == '0)) begin
                val = '0;
            end
            rdata_flat[i*DATA_WIDTH +: DATA_WIDTH] = val;
        end
    end

    assign bus.rdata = rdata_flat;
    assign bus.ready = ready_q;
endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp
// Directed bench for regfile_mp. Two instances run in lockstep on the same
// stimulus: dut_z with the hardwired zero register, dut_nz without it.
// Expectations for the bypass scenario follow REGFILE_MP_BYPASS_EN.
module tb_regfile_mp;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam int NR = 2;

    logic clk;
    logic rst;
    logic wen;
    logic [AW-1:0] waddr;
    logic [DW-1:0] wdata;
    logic [NR*AW-1:0] raddr;

    int checks;
    int errors;

    regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) bus_z ();
    regfile_mp_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR)) bus_nz ();

    assign bus_z.wen    = wen;
    assign bus_z.waddr  = waddr;
    assign bus_z.wdata  = wdata;
    assign bus_z.raddr  = raddr;
    assign bus_nz.wen   = wen;
    assign bus_nz.waddr = waddr;
    assign bus_nz.wdata = wdata;
    assign bus_nz.raddr = raddr;

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .ZERO_REG(1)) dut_z (
        .clk (clk),
        .rst (rst),
        .bus (bus_z)
    );

    regfile_mp #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NR_READ(NR), .ZERO_REG(0)) dut_nz (
        .clk (clk),
        .rst (rst),
        .bus (bus_nz)
    );

    logic [DW-1:0] z0, z1, nz0, nz1;
    assign z0  = bus_z.rdata[DW-1:0];
    assign z1  = bus_z.rdata[2*DW-1:DW];
    assign nz0 = bus_nz.rdata[DW-1:0];
    assign nz1 = bus_nz.rdata[2*DW-1:DW];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1ns after the edge.
    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic set_raddr(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_reset();
        wen = 1'b0;
        set_raddr(5'd1, 5'd2);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 1; k <= 32; k++) begin
            set_raddr(AW'(k), AW'(31 - k));
            #1;
            checks++;
            if (bus_z.ready !== 1'b0 || bus_nz.ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL reset_ready_low cycle %0d: got %b/%b expected 0", k, bus_z.ready, bus_nz.ready);
            end
            checks++;
            if (z0 !== '0 || z1 !== '0 || nz0 !== '0 || nz1 !== '0) begin
                errors++;
                $display("[TB] FAIL init_rdata_zero cycle %0d: got %h %h %h %h expected 0", k, z0, z1, nz0, nz1);
            end
            cycle();
        end
        checks++;
        if (bus_z.ready !== 1'b1 || bus_nz.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL reset_ready_high: got %b/%b expected 1", bus_z.ready, bus_nz.ready);
        end
        for (int i = 0; i < 32; i++) begin
            set_raddr(AW'(i), AW'(31 - i));
            #1;
            checks++;
            if (z0 !== '0 || z1 !== '0 || nz0 !== '0 || nz1 !== '0) begin
                errors++;
                $display("[TB] FAIL sweep_cleared entry %0d: got %h %h %h %h expected 0", i, z0, z1, nz0, nz1);
            end
        end
    endtask

    task automatic test_write_read();
        set_raddr(5'd1, 5'd2);
        wen = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        cycle();
        waddr = 5'd31; wdata = 32'h12345678;
        cycle();
        wen = 1'b0;
        set_raddr(5'd5, 5'd31);
        #1;
        checks++;
        if (z0 !== 32'hDEADBEEF || nz0 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL write_read_x5: got %h/%h expected deadbeef", z0, nz0);
        end
        checks++;
        if (z1 !== 32'h12345678 || nz1 !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL write_read_x31: got %h/%h expected 12345678", z1, nz1);
        end
    endtask

    task automatic test_zero_reg();
        set_raddr(5'd1, 5'd2);
        wen = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        cycle();
        wen = 1'b0;
        set_raddr(5'd0, 5'd0);
        #1;
        checks++;
        if (z0 !== '0 || z1 !== '0) begin
            errors++;
            $display("[TB] FAIL zero_reg_on: got %h %h expected 0", z0, z1);
        end
        checks++;
        if (nz0 !== 32'hFFFFFFFF || nz1 !== 32'hFFFFFFFF) begin
            errors++;
            $display("[TB] FAIL zero_reg_off: got %h %h expected ffffffff", nz0, nz1);
        end
    endtask

    task automatic test_bypass();
        logic [DW-1:0] exp_same;
        logic [DW-1:0] exp_x0_nz;
`ifdef REGFILE_MP_BYPASS_EN
        exp_same  = 32'hA5A5A5A5;
        exp_x0_nz = 32'h00000077;
`else
        exp_same  = 32'h00000000;
        exp_x0_nz = 32'hFFFFFFFF;
`endif
        wen = 1'b1; waddr = 5'd7; wdata = 32'hA5A5A5A5;
        set_raddr(5'd7, 5'd5);
        #2;
        checks++;
        if (z0 !== exp_same || nz0 !== exp_same) begin
            errors++;
            $display("[TB] FAIL bypass_same_cycle: got %h/%h expected %h", z0, nz0, exp_same);
        end
        checks++;
        if (z1 !== 32'hDEADBEEF) begin
            errors++;
            $display("[TB] FAIL bypass_other_port: got %h expected deadbeef", z1);
        end
        cycle();
        wen = 1'b0;
        #1;
        checks++;
        if (z0 !== 32'hA5A5A5A5 || nz0 !== 32'hA5A5A5A5) begin
            errors++;
            $display("[TB] FAIL bypass_next_cycle: got %h/%h expected a5a5a5a5", z0, nz0);
        end
        wen = 1'b1; waddr = 5'd0; wdata = 32'h00000077;
        set_raddr(5'd0, 5'd0);
        #2;
        checks++;
        if (z0 !== '0 || z1 !== '0) begin
            errors++;
            $display("[TB] FAIL bypass_x0_zero_reg: got %h %h expected 0", z0, z1);
        end
        checks++;
        if (nz0 !== exp_x0_nz) begin
            errors++;
            $display("[TB] FAIL bypass_x0_plain: got %h expected %h", nz0, exp_x0_nz);
        end
        cycle();
        wen = 1'b0;
    endtask

    task automatic test_reset_mid_sweep();
        wen = 1'b1; waddr = 5'd3; wdata = 32'h00000099;
        cycle();
        wen = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) cycle();
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd3; wdata = 32'h00000055;
        cycle();
        rst = 1'b0;
        set_raddr(5'd3, 5'd3);
        for (int k = 1; k <= 32; k++) begin
            #1;
            checks++;
            if (bus_z.ready !== 1'b0 || bus_nz.ready !== 1'b0) begin
                errors++;
                $display("[TB] FAIL restart_ready_low cycle %0d: got %b/%b expected 0", k, bus_z.ready, bus_nz.ready);
            end
            cycle();
        end
        wen = 1'b0;
        #1;
        checks++;
        if (bus_z.ready !== 1'b1 || bus_nz.ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL restart_ready_high: got %b/%b expected 1", bus_z.ready, bus_nz.ready);
        end
        checks++;
        if (z0 !== '0 || nz0 !== '0) begin
            errors++;
            $display("[TB] FAIL init_write_dropped x3: got %h/%h expected 0", z0, nz0);
        end
    endtask

    task automatic test_rst_wen_run();
        bit done;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h00000011;
        set_raddr(5'd9, 5'd1);
        cycle();
        wen = 1'b0;
        #1;
        checks++;
        if (z0 !== 32'h11 || nz0 !== 32'h11) begin
            errors++;
            $display("[TB] FAIL x9_before_reset: got %h/%h expected 11", z0, nz0);
        end
        rst = 1'b1;
        wen = 1'b1; waddr = 5'd9; wdata = 32'h00000022;
        cycle();
        rst = 1'b0;
        wen = 1'b0;
        checks++;
        if (bus_z.ready !== 1'b0) begin
            errors++;
            $display("[TB] FAIL rst_wen_ready_low: got %b expected 0", bus_z.ready);
        end
        done = 1'b0;
        for (int k = 0; k < 40 && !done; k++) begin
            cycle();
            if (bus_z.ready === 1'b1) done = 1'b1;
        end
        checks++;
        if (!done) begin
            errors++;
            $display("[TB] FAIL rst_wen_sweep_timeout: ready got %b expected 1", bus_z.ready);
        end
        #1;
        checks++;
        if (z0 !== '0 || nz0 !== '0) begin
            errors++;
            $display("[TB] FAIL rst_wen_x9: got %h/%h expected 0", z0, nz0);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        wen    = 1'b0;
        waddr  = '0;
        wdata  = '0;
        raddr  = '0;
        cycle();
        test_reset();
        test_write_read();
        test_zero_reg();
        test_bypass();
        test_reset_mid_sweep();
        test_rst_wen_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port integer register file; successor to the single-read-port GPR array in the NPC core.
- Adds N combinational read ports and a hardwired-zero register option.
- Adds a sequential post-reset clear sweep with a ready flag, and optional write-to-read bypass.
- Sits between decode (read addresses) and writeback (write port).

Parameters:
- ADDR_WIDTH, 5, register index width; DEPTH = 2**ADDR_WIDTH entries.
- DATA_WIDTH, 32, register width in bits.
- NR_READ, 2, number of independent read ports (1..4).
- ZERO_REG, 1, when 1 entry 0 reads as 0 and ignores writes; when 0 entry 0 is an ordinary register.

Ports:
- clk, input, 1, single clock, all state updates on posedge.
- rst, input, 1, synchronous active-high reset.
- wen, input, 1, write enable.
- waddr, input, ADDR_WIDTH, write index.
- wdata, input, DATA_WIDTH, write data.
- raddr, input, NR_READ*ADDR_WIDTH, flattened read indices; port i uses bits [i*ADDR_WIDTH +: ADDR_WIDTH].
- rdata, output, NR_READ*DATA_WIDTH, flattened read data; port i uses bits [i*DATA_WIDTH +: DATA_WIDTH].
- ready, output, 1, high when the array is initialised and accepting writes.

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- State machine has two states, INIT and RUN. The sweep counter is ADDR_WIDTH+1 bits.
- rst sampled high at posedge: go to INIT, sweep counter := 0, ready := 0. This holds from any state, including mid-sweep; the sweep restarts at entry 0.
- INIT, each cycle (rst low):
  - write 0 to entry[counter], then counter += 1.
  - when counter reaches DEPTH-1 and that entry is written, next state is RUN.
  - the sweep takes exactly DEPTH cycles after rst deasserts; ready goes 1 on the cycle after the last clear.
- INIT write rules: wen is ignored; writes are dropped, not queued.
- INIT read rule: all rdata ports output 0, regardless of raddr.
- RUN: on posedge, if wen && !(ZERO_REG && waddr==0), entry[waddr] := wdata. Otherwise the array is unchanged.
- Read ports are fully combinational, zero latency:
  - rdata_i = 0 if ZERO_REG && raddr_i==0.
  - otherwise rdata_i = entry[raddr_i] (subject to bypass below).
- Any number of read ports may address the same entry; all return identical data.
- Out-of-range indices cannot occur, because DEPTH = 2**ADDR_WIDTH.
- Reset values:
  - ready = 0 during and immediately after rst.
  - rdata = 0 throughout INIT.
  - array contents are all 0 once ready = 1.
- Simultaneous wen and rst: rst wins; the write is dropped.
- Writing entry 0 with ZERO_REG=0 is a normal write; with ZERO_REG=1 it has no effect.

Optional Feature:
- Macro: REGFILE_MP_BYPASS_EN.
- Defined, in RUN: if wen && waddr==raddr_i && !(ZERO_REG && waddr==0), then rdata_i = wdata in the same cycle (write-first forwarding). Applies independently per port.
- Not defined: rdata_i returns the pre-write array value during the write cycle; the new value is visible from the next cycle.
- In INIT, reads return 0 either way.

Test Plan:
- Reset sweep: pulse rst 1 cycle, DEPTH=32. Required: ready=0 for exactly 32 cycles after rst deasserts, ready=1 on cycle 33, and all 32 entries read back 0 on both ports.
- Write/read: in RUN, write 0xDEADBEEF to x5 and 0x12345678 to x31. Next cycle, with raddr0=5 and raddr1=31, required: rdata0=0xDEADBEEF, rdata1=0x12345678.
- Zero register: ZERO_REG=1, write 0xFFFFFFFF to x0, then read x0 on both ports. Required: 0. Repeat with ZERO_REG=0; required: 0xFFFFFFFF.
- Bypass: write 0xA5A5A5A5 to x7 while raddr0=7. Required: rdata0=0xA5A5A5A5 in the same cycle with REGFILE_MP_BYPASS_EN defined, and the old value (0) without it.
- Reset mid-sweep / writes during INIT:
  - assert rst at sweep cycle 10 while wen=1 writing 0x55 to x3.
  - required: sweep restarts with another full 32 cycles before ready=1, and x3 reads 0 afterward.
- Simultaneous rst+wen in RUN: x9=0x11, then assert rst with a write of 0x22 to x9. Required: after the sweep, x9 reads 0.
